// File: rtl/if_id_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage_buf
//  Description : Fetch-to-decode stage buffer with valid/ready handshake.
//                Define IF_ID_SKID_EN for the registered-ready two-entry skid;
//                otherwise the stage is a single register.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage_buf #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [1:0]             occupancy
);

    // State encoding doubles as the occupancy count; bit 1 marks a full skid.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b10;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [PC_WIDTH-1:0]    r_main_pc;
    logic [INSTR_WIDTH-1:0] r_main_instr;
    logic                   w_it;
    logic                   w_ot;
    logic                   w_load_main_in;

    assign out_valid = (r_state != EMPTY);
    assign out_pc    = r_main_pc;
    assign out_instr = r_main_instr;
    assign occupancy = r_state;
    assign w_it      = in_valid && in_ready;
    assign w_ot      = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef IF_ID_SKID_EN
    logic [PC_WIDTH-1:0]    r_skid_pc;
    logic [INSTR_WIDTH-1:0] r_skid_instr;
    logic                   w_load_skid;
    logic                   w_load_main_skid;

    // Ready comes straight from the state flop, isolating fetch from decode.
    assign in_ready = ~r_state[1];

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_skid      = 1'b0;
        w_load_main_skid = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_it) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_it && w_ot) begin
                        w_load_main_in = 1'b1;
                    end else if (w_it) begin
                        w_state_nxt = TWO;
                        w_load_skid = 1'b1;
                    end else if (w_ot) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_ot) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else if (w_load_skid) begin
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_pc    <= '0;
            r_main_instr <= '0;
        end else if (w_load_main_skid) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
        end else if (w_load_main_in) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
        end
    end
`else
    // Without a skid the register may refill in the same cycle it drains.
    assign in_ready = (r_state == EMPTY) || out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main_in = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_it) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_it) begin
                        w_load_main_in = 1'b1;
                    end else if (w_ot) begin
                        w_state_nxt = EMPTY;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_pc    <= '0;
            r_main_instr <= '0;
        end else if (w_load_main_in) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage_buf
//  Description : Directed self-checking bench for if_id_stage_buf (either build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stage_buf #(.PC_WIDTH(64), .INSTR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_occ",       occupancy, 0);
        check("rst_out_pc",    out_pc,    0);
        @(posedge clk); #3;
        reset = 1'b1;
        cyc();

        // Streaming at full throughput
        out_ready = 1'b1;
        drive(1'b1, 64'h0, 32'hD503201F);
        cyc();
        check("str0_valid", out_valid, 1);
        check("str0_pc",    out_pc,    64'h0);
        check("str0_instr", out_instr, 32'hD503201F);
        check("str0_occ",   occupancy, 1);
        drive(1'b1, 64'h4, 32'h8B020020);
        #1 check("str1_in_ready", in_ready, 1);
        cyc();
        check("str1_pc",    out_pc,    64'h4);
        check("str1_instr", out_instr, 32'h8B020020);
        check("str1_occ",   occupancy, 1);
        drive(1'b1, 64'h8, 32'hF8400041);
        cyc();
        check("str2_pc",    out_pc,    64'h8);
        check("str2_instr", out_instr, 32'hF8400041);
        check("str2_occ",   occupancy, 1);
        drive(1'b0, 64'h0, 32'h0);
        cyc();
        check("drain_valid", out_valid, 0);
        check("drain_occ",   occupancy, 0);

        // Simultaneous transfer in ONE
        out_ready = 1'b0;
        drive(1'b1, 64'h30, 32'h11111111);
        cyc();
        check("hold30_pc",  out_pc,    64'h30);
        check("hold30_occ", occupancy, 1);
        drive(1'b1, 64'h34, 32'h22222222);
        out_ready = 1'b1;
        cyc();
        check("sim_pc",    out_pc,    64'h34);
        check("sim_instr", out_instr, 32'h22222222);
        check("sim_occ",   occupancy, 1);
`ifdef IF_ID_SKID_EN
        drive(1'b0, 64'h0, 32'h0);
        cyc();
        check("sim_drain", out_valid, 0);

        // Backpressure into the skid
        out_ready = 1'b0;
        drive(1'b1, 64'h10, 32'hA0000010);
        cyc();
        check("bp10_occ",   occupancy, 1);
        check("bp10_ready", in_ready,  1);
        drive(1'b1, 64'h14, 32'hA0000014);
        cyc();
        check("bp14_occ",   occupancy, 2);
        check("bp14_ready", in_ready,  0);
        check("bp14_pc",    out_pc,    64'h10);
        drive(1'b1, 64'h18, 32'hA0000018);
        cyc();
        check("bp18_occ",  occupancy, 2);
        check("bp18_pc",   out_pc,    64'h10);
        out_ready = 1'b1;
        cyc();
        check("rel14_pc",    out_pc,    64'h14);
        check("rel14_instr", out_instr, 32'hA0000014);
        check("rel14_occ",   occupancy, 1);
        check("rel14_ready", in_ready,  1);
        cyc();
        check("rel18_pc",  out_pc,    64'h18);
        check("rel18_occ", occupancy, 1);
        drive(1'b0, 64'h0, 32'h0);
        cyc();
        check("rel_drain", out_valid, 0);

        // Flush while TWO, with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 64'h24, 32'hB0000024);
        cyc();
        drive(1'b1, 64'h28, 32'hB0000028);
        cyc();
        check("ft_occ2", occupancy, 2);
        flush = 1'b1;
        drive(1'b1, 64'h20, 32'hB0000020);
        cyc();
        check("ft_valid", out_valid, 0);
        check("ft_occ",   occupancy, 0);
        check("ft_ready", in_ready,  1);
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        out_ready = 1'b1;
        cyc();
        check("ft_no20", out_valid, 0);
`else
        // Single register: ready follows out_ready combinationally
        out_ready = 1'b0;
        drive(1'b1, 64'h40, 32'hC0000040);
        #1 check("nsk_ready_lo", in_ready, 0);
        cyc();
        check("nsk_hold_pc",  out_pc,    64'h34);
        check("nsk_hold_occ", occupancy, 1);
        out_ready = 1'b1;
        #1 check("nsk_ready_hi", in_ready, 1);
        cyc();
        check("nsk40_pc",    out_pc,    64'h40);
        check("nsk40_instr", out_instr, 32'hC0000040);
        drive(1'b0, 64'h0, 32'h0);
        cyc();
        check("nsk_drain", out_valid, 0);
`endif

        // Flush in ONE discards a concurrent push; next push visible at N+2
        out_ready = 1'b0;
        drive(1'b1, 64'h50, 32'hD0000050);
        cyc();
        check("f1_occ", occupancy, 1);
        flush = 1'b1;
        drive(1'b1, 64'h54, 32'hD0000054);
        cyc();
        check("f1_valid", out_valid, 0);
        check("f1_occ0",  occupancy, 0);
        check("f1_ready", in_ready,  1);
        flush = 1'b0;
        drive(1'b1, 64'h58, 32'hD0000058);
        cyc();
        check("f1_58_pc",    out_pc,    64'h58);
        check("f1_58_instr", out_instr, 32'hD0000058);
        check("f1_58_occ",   occupancy, 1);

        // Asynchronous reset mid-stream
        drive(1'b1, 64'h60, 32'hE0000060);
        cyc();
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_occ",   occupancy, 0);
        check("ar_pc",    out_pc,    0);
        check("ar_instr", out_instr, 0);
        check("ar_ready", in_ready,  1);
        cyc();
        check("ar_ignore_in", out_valid, 0);
        #2;
        reset = 1'b1;
        drive(1'b0, 64'h0, 32'h0);
        cyc();
        check("ar_after", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
